// File: rtl/winograd_tile_buffer.sv
// Winograd F(2x2,3x3) input-tile feeder.
// Buffers the last three image rows of a raster pixel stream and emits overlapping
// 4x4xCHANNELS tiles at stride 2, one per 2x2 output block of the valid convolution.
module winograd_tile_buffer #(
  parameter int unsigned INPUT_TILE_SIZE  = 4,
  parameter int unsigned INPUT_DATA_WIDTH = 8,
  parameter int unsigned CHANNELS         = 3,
  parameter int unsigned IMG_W            = 8,
  parameter int unsigned IMG_H            = 8
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  input  logic [CHANNELS*INPUT_DATA_WIDTH-1:0]                    s_data,
  input  logic                                                    s_valid,
  output logic                                                    s_ready,
  output logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*CHANNELS*INPUT_DATA_WIDTH-1:0] inpData,
  output logic                                                    o_valid,
  output logic [$clog2(IMG_H/2)-1:0]                              tile_row,
  output logic [$clog2(IMG_W/2)-1:0]                              tile_col,
  output logic                                                    frame_done,
  output logic                                                    busy
);

  localparam int unsigned TS  = INPUT_TILE_SIZE;
  localparam int unsigned W   = INPUT_DATA_WIDTH;
  localparam int unsigned PW  = CHANNELS * W;
  localparam int unsigned TW  = TS * TS * PW;
  localparam int unsigned CW  = $clog2(IMG_W);
  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned TRW = $clog2(IMG_H / 2);
  localparam int unsigned TCW = $clog2(IMG_W / 2);

  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            accept;
  logic            emit;
  logic            last_px;
  logic [RW-1:0]   row_m3;
  logic [CW-1:0]   col_m3;

  // Line buffers: index 0 holds row r-3, 1 holds r-2, 2 holds r-1.
  logic [PW-1:0]   lb_q  [3][IMG_W];
  // Window: [row top..bottom][col left..right].
  logic [PW-1:0]   win_q [TS][TS];
  logic [PW-1:0]   win_d [TS][TS];
  logic [TW-1:0]   tile_d;

  assign accept  = s_valid && s_ready;
  assign last_px = accept && (row_q == RowLast) && (col_q == ColLast);
  // A tile completes on odd row/col at or beyond index 3 (bottom-right of a 4x4 window).
  assign emit    = accept && (row_q >= RW'(3)) && row_q[0] && (col_q >= CW'(3)) && col_q[0];
  assign row_m3  = row_q - RW'(3);
  assign col_m3  = col_q - CW'(3);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (last_px) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Raster position counters; cleared when a frame is armed.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == StIdle && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Next window: shift left, new right column is {r-3, r-2, r-1, incoming pixel}.
  always_comb begin
    for (int r = 0; r < TS; r++) begin
      for (int k = 0; k < TS; k++) begin
        win_d[r][k] = win_q[r][k];
      end
    end
    if (accept) begin
      for (int r = 0; r < TS; r++) begin
        for (int k = 0; k < TS - 1; k++) begin
          win_d[r][k] = win_q[r][k+1];
        end
      end
      win_d[0][TS-1] = lb_q[0][col_q];
      win_d[1][TS-1] = lb_q[1][col_q];
      win_d[2][TS-1] = lb_q[2][col_q];
      win_d[3][TS-1] = s_data;
    end
  end

  // Flatten the next window into PE order: channel-major, row 0 col 0 at the high end.
  always_comb begin
    tile_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int r = 0; r < TS; r++) begin
        for (int k = 0; k < TS; k++) begin
          tile_d[((c*TS*TS + (TS-1-r)*TS + (TS-1-k))*W) +: W] = win_d[r][k][c*W +: W];
        end
      end
    end
  end

  // Line buffer and window storage; contents need no reset since every tile is fully refreshed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][col_q] <= lb_q[1][col_q];
      lb_q[1][col_q] <= lb_q[2][col_q];
      lb_q[2][col_q] <= s_data;
    end
    for (int r = 0; r < TS; r++) begin
      for (int k = 0; k < TS; k++) begin
        win_q[r][k] <= win_d[r][k];
      end
    end
  end

  // Tile output registers; data and indices hold between emissions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inpData    <= '0;
      o_valid    <= 1'b0;
      frame_done <= 1'b0;
      tile_row   <= '0;
      tile_col   <= '0;
    end else begin
      o_valid    <= emit;
      frame_done <= emit && last_px;
      if (emit) begin
        inpData  <= tile_d;
        tile_row <= TRW'(row_m3[RW-1:1]);
        tile_col <= TCW'(col_m3[CW-1:1]);
      end
    end
  end

endmodule

// File: tb/tb_winograd_tile_buffer.sv
module tb_winograd_tile_buffer;

  localparam int unsigned W  = 8;
  localparam int unsigned C  = 3;
  localparam int unsigned PW = C * W;
  localparam int unsigned TW = 16 * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] s_data;
  logic          s_valid;
  int            sel;  // 0 selects the 4x4 instance, 1 the 6x6 instance

  logic          a_start, a_valid, a_ready, a_ovalid, a_fdone, a_busy;
  logic [TW-1:0] a_data;
  logic [0:0]    a_trow, a_tcol;
  logic          b_start, b_valid, b_ready, b_ovalid, b_fdone, b_busy;
  logic [TW-1:0] b_data;
  logic [1:0]    b_trow, b_tcol;

  logic          m_ready, m_ovalid, m_fdone, m_busy;
  logic [TW-1:0] m_data;
  logic [1:0]    m_trow, m_tcol;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pix [6][6][C];

  always #5 clk = ~clk;

  assign a_start = start && (sel == 0);
  assign a_valid = s_valid && (sel == 0);
  assign b_start = start && (sel == 1);
  assign b_valid = s_valid && (sel == 1);

  winograd_tile_buffer #(
    .INPUT_TILE_SIZE(4), .INPUT_DATA_WIDTH(W), .CHANNELS(C), .IMG_W(4), .IMG_H(4)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .s_data(s_data), .s_valid(a_valid),
    .s_ready(a_ready), .inpData(a_data), .o_valid(a_ovalid), .tile_row(a_trow),
    .tile_col(a_tcol), .frame_done(a_fdone), .busy(a_busy)
  );

  winograd_tile_buffer #(
    .INPUT_TILE_SIZE(4), .INPUT_DATA_WIDTH(W), .CHANNELS(C), .IMG_W(6), .IMG_H(6)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .s_data(s_data), .s_valid(b_valid),
    .s_ready(b_ready), .inpData(b_data), .o_valid(b_ovalid), .tile_row(b_trow),
    .tile_col(b_tcol), .frame_done(b_fdone), .busy(b_busy)
  );

  always_comb begin
    m_ready  = b_ready;
    m_ovalid = b_ovalid;
    m_fdone  = b_fdone;
    m_busy   = b_busy;
    m_data   = b_data;
    m_trow   = b_trow;
    m_tcol   = b_tcol;
    if (sel == 0) begin
      m_ready  = a_ready;
      m_ovalid = a_ovalid;
      m_fdone  = a_fdone;
      m_busy   = a_busy;
      m_data   = a_data;
      m_trow   = {1'b0, a_trow};
      m_tcol   = {1'b0, a_tcol};
    end
  end

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // pattern=1: ch0 = r*4+k+1, ch1 = 1, ch2 = -(r*4+k+1); otherwise random.
  task automatic fill(input bit pattern);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 6; k++) begin
        for (int c = 0; c < C; c++) begin
          if (pattern) begin
            if (c == 0)      pix[r][k][c] = W'(r*4 + k + 1);
            else if (c == 1) pix[r][k][c] = W'(1);
            else             pix[r][k][c] = W'(-(r*4 + k + 1));
          end else begin
            pix[r][k][c] = W'($urandom);
          end
        end
      end
    end
  endtask

  function automatic logic [PW-1:0] pixel(input int r, input int k);
    logic [PW-1:0] p;
    for (int c = 0; c < C; c++) p[c*W +: W] = pix[r][k][c];
    return p;
  endfunction

  // Tile (tr,tc) covers pixel rows 2tr..2tr+3 and columns 2tc..2tc+3.
  function automatic logic [TW-1:0] exp_tile(input int tr, input int tc);
    logic [TW-1:0] t;
    t = '0;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          t[((c*16 + (3-r)*4 + (3-k))*W) +: W] = pix[2*tr + r][2*tc + k][c];
    return t;
  endfunction

  task automatic run_frame(input int s, input int h, input int w, input bit bubbles,
                           input int mid_start, input int stop_after);
    int n;
    bit emit;
    sel = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_armed", TW'(m_busy), TW'(1));
    check("ready_armed", TW'(m_ready), TW'(1));
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        if (stop_after >= 0 && n == stop_after) return;
        if (bubbles && n > 0) begin
          s_valid = 1'b0;
          s_data  = PW'($urandom);
          @(posedge clk); #1;
          check("bubble_ovalid", TW'(m_ovalid), TW'(0));
        end
        s_data  = pixel(r, k);
        s_valid = 1'b1;
        start   = (n == mid_start);
        @(posedge clk); #1;
        s_valid = 1'b0;
        start   = 1'b0;
        n++;
        emit = (r >= 3) && (r % 2 == 1) && (k >= 3) && (k % 2 == 1);
        check("o_valid", TW'(m_ovalid), TW'(emit));
        if (emit) begin
          check("inpData", m_data, exp_tile((r-3)/2, (k-3)/2));
          check("tile_row", TW'(m_trow), TW'((r-3)/2));
          check("tile_col", TW'(m_tcol), TW'((k-3)/2));
          check("frame_done", TW'(m_fdone), TW'((r == h-1) && (k == w-1)));
        end else begin
          check("frame_done_idle", TW'(m_fdone), TW'(0));
        end
      end
    end
    check("busy_end", TW'(m_busy), TW'(0));
    check("ready_end", TW'(m_ready), TW'(0));
  endtask

  initial begin
    logic [TW-1:0] held;
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    sel     = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", TW'(m_busy), TW'(0));
    check("rst_ready", TW'(m_ready), TW'(0));
    check("rst_ovalid", TW'(m_ovalid), TW'(0));
    check("rst_data", m_data, TW'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // 4x4 fixed pattern: single tile
    fill(1'b1);
    run_frame(0, 4, 4, 1'b0, -1, -1);
    held = m_data;
    check("pat_lsb", TW'(held[7:0]), TW'(16));
    check("pat_ch0_msb", TW'(held[127:120]), TW'(1));
    check("pat_ch2_lsb", TW'(held[263:256]), TW'(8'hF0));
    check("pat_ch2_msb", TW'(held[383:376]), TW'(8'hFF));
    repeat (3) @(posedge clk);
    #1;
    check("hold_data", m_data, held);
    check("hold_ovalid", TW'(m_ovalid), TW'(0));

    // 6x6 random, then same pixels with alternating bubbles
    fill(1'b0);
    run_frame(1, 6, 6, 1'b0, -1, -1);
    run_frame(1, 6, 6, 1'b1, -1, -1);

    // start re-asserted mid-frame must be ignored
    fill(1'b0);
    run_frame(1, 6, 6, 1'b0, 5, -1);
    // beats offered while idle must not be taken
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = PW'($urandom);
      @(posedge clk); #1;
      check("idle_ovalid", TW'(m_ovalid), TW'(0));
      check("idle_busy", TW'(m_busy), TW'(0));
    end
    s_valid = 1'b0;
    fill(1'b0);
    run_frame(1, 6, 6, 1'b0, -1, -1);

    // asynchronous reset after 10 accepts
    fill(1'b0);
    run_frame(1, 6, 6, 1'b0, -1, 10);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_data", m_data, TW'(0));
    check("mid_rst_trow", TW'(m_trow), TW'(0));
    check("mid_rst_tcol", TW'(m_tcol), TW'(0));
    check("mid_rst_busy", TW'(m_busy), TW'(0));
    check("mid_rst_ready", TW'(m_ready), TW'(0));
    check("mid_rst_ovalid", TW'(m_ovalid), TW'(0));
    check("mid_rst_fdone", TW'(m_fdone), TW'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    fill(1'b0);
    run_frame(1, 6, 6, 1'b0, -1, -1);

    // two back-to-back 4x4 frames
    fill(1'b0);
    run_frame(0, 4, 4, 1'b0, -1, -1);
    fill(1'b0);
    run_frame(0, 4, 4, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/winograd_tile_buffer.md
Name: winograd_tile_buffer

Overview:
Upstream feeder for the Winograd F(2x2,3x3) PE. Accepts a raster-order pixel stream, where each beat carries all CHANNELS values of one pixel, and buffers the last three image rows in line buffers. It emits overlapping 4x4xCHANNELS input tiles at stride 2 on the PE's flattened inpData bus, together with a single-cycle o_valid pulse. One tile is produced per 2x2 output block of the valid (unpadded) convolution.

Parameters:
INPUT_TILE_SIZE, 4, tile edge; fixed at 4 for F(2x2,3x3).
INPUT_DATA_WIDTH, 8, signed bits per element.
CHANNELS, 3, input channels per pixel.
IMG_W, 8, image width in pixels; must be even and >=4.
IMG_H, 8, image height in pixels; must be even and >=4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  pulse; arms a new frame while IDLE
s_data  input  CHANNELS*INPUT_DATA_WIDTH  one pixel; channel c occupies [c*W +: W]
s_valid  input  1  s_data valid
s_ready  output  1  high while RUN
inpData  output  16*CHANNELS*INPUT_DATA_WIDTH  flattened tile, PE ordering
o_valid  output  1  one-cycle pulse; inpData is new
tile_row  output  clog2(IMG_H/2)  tile row index of the current inpData
tile_col  output  clog2(IMG_W/2)  tile column index of the current inpData
frame_done  output  1  one-cycle pulse, coincident with the last tile's o_valid
busy  output  1  high in RUN

Behaviour:
- Reset (reset low, asynchronous):
  - State returns to IDLE.
  - s_ready, o_valid, frame_done and busy go to 0.
  - inpData, tile_row and tile_col go to 0.
  - Row and column counters clear.
  - Line buffer contents need not be cleared.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> IDLE in the cycle after the final pixel (row IMG_H-1, col IMG_W-1) is accepted.
  - start is ignored in RUN.
- Handshake:
  - A pixel is accepted when s_valid && s_ready.
  - s_ready = (state==RUN); it is combinational from state only.
  - Bubbles (s_valid low) stall all counters and shifts.
- Counters:
  - col advances 0..IMG_W-1 on each accept, then wraps to 0 and increments row.
  - Both counters clear on entering RUN.
- Storage:
  - 3 line buffers (rows r-3, r-2, r-1), each IMG_W x CHANNELS*W bits, written at index col on accept.
  - A 4x4xCHANNELS window register shifts left one column per accept.
  - The new rightmost column, top to bottom, is {lb_r-3[col], lb_r-2[col], lb_r-1[col], s_data}.
- Emission:
  - Triggered on accept of a pixel with row>=3, row odd, col>=3, col odd.
  - On the next rising edge:
    - inpData <= window including the just-accepted pixel;
    - o_valid <= 1;
    - tile_row <= (row-3)/2;
    - tile_col <= (col-3)/2.
  - Latency is 1 cycle from the completing accept.
  - Tiles per frame = ((IMG_H-2)/2)*((IMG_W-2)/2).
  - Tiles are at least 2 cycles apart.
  - inpData, tile_row and tile_col hold until the next emission.
- Ordering (PE contract):
  - Element (channel c, tile row r, tile col k) occupies bits [((c*16 + (3-r)*4 + (3-k))*W) +: W].
  - Channel CHANNELS-1 is at the MSB end; channel 0, row 3, col 3 is at [W-1:0].
  - Values pass through unmodified, signed, with no width growth.
- frame_done is asserted with the o_valid of tile ((IMG_H-2)/2-1, (IMG_W-2)/2-1).
- Window columns from the previous row do not corrupt the first tile of a row: that tile requires col>=3, by which point the window is fully refreshed.
- Reset mid-frame: the next frame starts cleanly after start. No spurious o_valid is produced.

Test Plan:
- IMG_W=IMG_H=4, C=3, pixel(r,k) ch0=r*4+k+1, ch1=1, ch2=-(r*4+k+1); feed 16 beats back-to-back. Expect exactly one o_valid, 1 cycle after the 16th accept, with tile_row=tile_col=0 and frame_done=1. inpData[127:0] carries ch0 values 1..16 MSB-first; [7:0]=16; ch2 elements = -1..-16 (sign preserved).
- IMG_W=IMG_H=6: expect 4 tiles in order (0,0), (0,1), (1,0), (1,1). Completing pixels are (3,3), (3,5), (5,3), (5,5). Tile (0,1) top-left element = pixel(0,2). frame_done only on the 4th tile.
- IMG_W=IMG_H=6 with s_valid toggling 1,0,1,0…: same 4 tiles with identical contents; o_valid is never asserted during a bubble cycle that follows a non-completing accept.
- start asserted mid-RUN: no counter reset; tile sequence unchanged. After frame end, busy=0, s_ready=0, and s_valid beats are not accepted.
- Assert reset low after 10 accepts of a 6x6 frame: all outputs are 0 asynchronously. Then start and a full frame yield 4 correct tiles with no stale data.
- Two consecutive 4x4 frames, start re-issued between them: the second tile reflects only second-frame pixels.
